inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_fetch_buf.sv | 40 ++++
 rtl/inst_fetch.sv | 87 ++++++++
 tb/tb_inst_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, PC constants
// and a word-alignment helper used by the fetch datapath.
package inst_fetch_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_fetch_buf.sv
// One-entry hold register for a fetched instruction and its address; the valid
// flag is the handshake toward decode, the payload simply holds its last load.
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc;

  // Clear wins so a squash can never leave a stale entry marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= RESET_PC;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request at a time, a single
// instruction buffer toward decode, and redirect handling including draining.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  output logic               pc_en,
  output logic [31:0]        pc_next,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);

  fetch_state_e r_state;
  fetch_state_e w_stateNext;
  logic         w_bufLoad;
  logic         w_bufClear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // A redirect in REQ without its ack leaves a request in flight, so DRAIN
  // swallows that ack; an ack in DRAIN ends the drain even with a new redirect.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:  w_stateNext = redirect ? IDLE : REQ;
      REQ: begin
        if (redirect)      w_stateNext = imem_ack ? IDLE : DRAIN;
        else if (imem_ack) w_stateNext = FULL;
      end
      FULL:  if (redirect || id_ready) w_stateNext = IDLE;
      DRAIN: if (imem_ack) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Redirect always owns the PC write port; sequential advance only on a
  // clean ack. Outputs are forced to their reset values while rst is high.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    pc_en      = 1'b0;
    pc_next    = '0;
    w_bufLoad  = 1'b0;
    w_bufClear = 1'b0;
    if (!rst) begin
      if (r_state == REQ) begin
        imem_req  = 1'b1;
        imem_addr = wordAlign(pc);
      end
      if (redirect) begin
        pc_en   = 1'b1;
        pc_next = wordAlign(redirect_pc);
      end else if (r_state == REQ && imem_ack) begin
        pc_en   = 1'b1;
        pc_next = pc + PC_STEP;
      end
      w_bufLoad  = (r_state == REQ) && imem_ack && !redirect;
      w_bufClear = (r_state == FULL) && (redirect || id_ready);
    end
  end

  fetch_buf u_fetchBuf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_bufLoad),
    .i_clear (w_bufClear),
    .i_instr (imem_rdata),
    .i_pc    (pc),
    .o_valid (if_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: table-driven sequential fetches plus
// directed sequences for stalls, redirects, draining and reset mid-request.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct {
    logic [31:0] startPc;
    logic [31:0] rdata;
    logic [31:0] expNext;
  } fetchVec_t;

  fetchVec_t vecs[4];

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_en       (pc_en),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Models the external PC register: it loads pc_next on an edge where pc_en was high.
  task automatic nextCycle();
    logic        en;
    logic [31:0] nx;
    en = pc_en;
    nx = pc_next;
    @(posedge clk);
    #1;
    if (rst)     pc = 32'h0;
    else if (en) pc = nx;
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic redir, input logic [31:0] rpc,
                               input logic ready);
    imem_ack    = ack;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    id_ready    = ready;
    #1;
  endtask

  // From IDLE: request, zero-wait ack, buffer, transfer, back to IDLE.
  task automatic simpleFetch(input logic [31:0] data);
    nextCycle();
    applyStimulus(1'b1, data, 1'b0, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    nextCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0004};
    vecs[1] = '{32'h0000_0100, 32'hDEAD_0001, 32'h0000_0104};
    vecs[2] = '{32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000};
    vecs[3] = '{32'h7FFF_FFF8, 32'hA5A5_A5A5, 32'h7FFF_FFFC};

    rst = 1'b1; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst imem_req", imem_req, 1'b0);
    checkOutput("rst imem_addr", imem_addr, 32'h0);
    checkOutput("rst pc_en", pc_en, 1'b0);
    checkOutput("rst pc_next", pc_next, 32'h0);
    checkOutput("rst if_valid", if_valid, 1'b0);
    checkOutput("rst if_instr", if_instr, 32'h0);
    checkOutput("rst if_pc", if_pc, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      pc = vecs[i].startPc;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("idle imem_req", imem_req, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("vec imem_req", imem_req, 1'b1);
      checkOutput("vec imem_addr", imem_addr, vecs[i].startPc);
      checkOutput("vec pc_en idle", pc_en, 1'b0);
      applyStimulus(1'b1, vecs[i].rdata, 1'b0, 32'h0, 1'b1);
      checkOutput("vec pc_en", pc_en, 1'b1);
      checkOutput("vec pc_next", pc_next, vecs[i].expNext);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("vec if_valid", if_valid, 1'b1);
      checkOutput("vec if_instr", if_instr, vecs[i].rdata);
      checkOutput("vec if_pc", if_pc, vecs[i].startPc);
      checkOutput("vec full imem_req", imem_req, 1'b0);
      checkOutput("vec full pc_en", pc_en, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("vec if_valid after transfer", if_valid, 1'b0);
    end

    // Decode stalls for five cycles while the buffer is full.
    pc = 32'h0000_0040;
    nextCycle();
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("stall if_valid", if_valid, 1'b1);
      checkOutput("stall if_instr", if_instr, 32'hCAFE_F00D);
      checkOutput("stall if_pc", if_pc, 32'h0000_0040);
      checkOutput("stall imem_req", imem_req, 1'b0);
      checkOutput("stall pc_en", pc_en, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("stall release if_valid", if_valid, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("stall done if_valid", if_valid, 1'b0);

    // Redirect while the buffer holds an instruction.
    pc = 32'h0000_0200;
    nextCycle();
    applyStimulus(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b0);
    checkOutput("full redir pc_en", pc_en, 1'b1);
    checkOutput("full redir pc_next", pc_next, 32'h0000_0100);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("full redir if_valid", if_valid, 1'b0);
    checkOutput("full redir imem_req", imem_req, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("full redir fetch addr", imem_addr, 32'h0000_0100);
    applyStimulus(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
    checkOutput("full redir pc_next", pc_next, 32'h0000_0104);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("full redir if_instr", if_instr, 32'h2222_2222);
    checkOutput("full redir if_pc", if_pc, 32'h0000_0100);
    nextCycle();

    // Redirect in IDLE holds IDLE for one cycle.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0051, 1'b1);
    checkOutput("idle redir pc_en", pc_en, 1'b1);
    checkOutput("idle redir pc_next", pc_next, 32'h0000_0050);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("idle redir hold imem_req", imem_req, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("idle redir imem_addr", imem_addr, 32'h0000_0050);
    checkOutput("idle redir imem_req", imem_req, 1'b1);
    applyStimulus(1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    nextCycle();

    // Redirect in REQ, a second redirect in DRAIN, late ack with poison data.
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b1);
    checkOutput("req redir imem_req", imem_req, 1'b1);
    checkOutput("req redir pc_en", pc_en, 1'b1);
    checkOutput("req redir pc_next", pc_next, 32'h0000_0300);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain imem_req", imem_req, 1'b0);
    checkOutput("drain pc_en", pc_en, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0406, 1'b1);
    checkOutput("drain redir pc_en", pc_en, 1'b1);
    checkOutput("drain redir pc_next", pc_next, 32'h0000_0404);
    nextCycle();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    checkOutput("drain ack imem_req", imem_req, 1'b0);
    checkOutput("drain ack pc_en", pc_en, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain done if_valid", if_valid, 1'b0);
    checkOutput("drain done imem_req", imem_req, 1'b0);
    compareCount++;
    if (if_instr === 32'hDEAD_BEEF) begin
      mismatchCount++;
      $display("[TB] FAIL drain discard: got %h, expected anything but deadbeef", if_instr);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain next fetch addr", imem_addr, 32'h0000_0404);
    applyStimulus(1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain refetch if_instr", if_instr, 32'h4444_4444);
    checkOutput("drain refetch if_pc", if_pc, 32'h0000_0404);
    nextCycle();

    // Reset while a request is outstanding; the late ack must be ignored.
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("pre-rst imem_req", imem_req, 1'b1);
    rst = 1'b1;
    pc  = 32'h0;
    #1;
    checkOutput("mid rst imem_req", imem_req, 1'b0);
    checkOutput("mid rst imem_addr", imem_addr, 32'h0);
    checkOutput("mid rst pc_en", pc_en, 1'b0);
    checkOutput("mid rst pc_next", pc_next, 32'h0);
    checkOutput("mid rst if_valid", if_valid, 1'b0);
    checkOutput("mid rst if_instr", if_instr, 32'h0);
    checkOutput("mid rst if_pc", if_pc, 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 32'hBADB_AD00, 1'b0, 32'h0, 1'b1);
    checkOutput("late ack pc_en", pc_en, 1'b0);
    checkOutput("late ack imem_req", imem_req, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("late ack if_valid", if_valid, 1'b0);
    checkOutput("post rst imem_addr", imem_addr, 32'h0);
    checkOutput("post rst imem_req", imem_req, 1'b1);
    applyStimulus(1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
    checkOutput("post rst pc_next", pc_next, 32'h0000_0004);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("post rst if_instr", if_instr, 32'h5555_5555);
    nextCycle();

    simpleFetch(32'h6666_6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
